// File: rtl/vic_bus_scheduler_if.sv
// Bus-scheduling signals between the VIC6569 phi0/raster control and the
// memory/CPU side. The master modport belongs to the scheduler.
interface vic_bus_scheduler_if;
  logic       i_halfTick;
  logic       i_den;
  logic [2:0] i_yscroll;
  logic [7:0] i_spriteDma;

  logic       o_phi;
  logic [5:0] o_cycle;
  logic [8:0] o_raster;
  logic       o_badline;
  logic       o_ba;
  logic       o_aec;
  logic [2:0] o_access;
  logic [2:0] o_sprite;

  modport master (
    input  i_halfTick, i_den, i_yscroll, i_spriteDma,
    output o_phi, o_cycle, o_raster, o_badline, o_ba, o_aec, o_access, o_sprite
  );

  modport slave (
    output i_halfTick, i_den, i_yscroll, i_spriteDma,
    input  o_phi, o_cycle, o_raster, o_badline, o_ba, o_aec, o_access, o_sprite
  );
endinterface

// File: rtl/vic_bus_scheduler.sv
// Cycle-exact VIC6569 (PAL) bus scheduler: tracks raster/cycle/phase and
// decodes bus ownership, BA/AEC and the VIC access type every half-cycle.
module vic_bus_scheduler #(
  parameter int CYCLES_PER_LINE = 63,
  parameter int LINES_PER_FRAME = 312
) (
  input  logic                clk,
  input  logic                reset,
  vic_bus_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    ACC_IDLE    = 3'd0,
    ACC_REFRESH = 3'd1,
    ACC_C       = 3'd2,
    ACC_G       = 3'd3,
    ACC_P       = 3'd4,
    ACC_S       = 3'd5,
    ACC_CPU     = 3'd7
  } access_e;

  localparam logic [8:0] DISP_FIRST = 9'h030;
  localparam logic [8:0] DISP_LAST  = 9'h0F7;

  // Sprite pointer-fetch slot (phi1 of this cycle) for sprites 0..7.
  function automatic logic [5:0] slot_of(input int n);
    case (n)
      0:       return 6'd58;
      1:       return 6'd60;
      2:       return 6'd62;
      3:       return 6'd1;
      4:       return 6'd3;
      5:       return 6'd5;
      6:       return 6'd7;
      default: return 6'd9;
    endcase
  endfunction

  function automatic logic [5:0] cyc_add(input logic [5:0] c, input int k);
    int v;
    v = (int'(c) - 1 + k + CYCLES_PER_LINE) % CYCLES_PER_LINE;
    return 6'(v + 1);
  endfunction

  function automatic logic in_span(input logic [5:0] c, input logic [5:0] start,
                                   input int len);
    int d;
    d = (int'(c) - int'(start) + CYCLES_PER_LINE) % CYCLES_PER_LINE;
    return d < len;
  endfunction

  logic       r_phi;
  logic [5:0] r_cycle;
  logic [8:0] r_raster;
  logic       r_den_latch;
  logic [7:0] r_dma_mask;

  logic       w_line_end;
  logic       w_frame_end;
  logic       w_window;
  logic       w_badline;
  logic       w_spr_ba;
  logic       w_p_hit;
  logic [2:0] w_p_idx;
  logic       w_s1_hit;
  logic [2:0] w_s1_idx;
  access_e    w_access;
  logic [2:0] w_sprite;

  assign w_line_end  = r_phi && (r_cycle == 6'(CYCLES_PER_LINE));
  assign w_frame_end = w_line_end && (r_raster == 9'(LINES_PER_FRAME - 1));

  // NOTE: synchronous reset has priority over a coincident half-tick, and all
  // state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phi       <= 1'b0;
      r_cycle     <= 6'd1;
      r_raster    <= '0;
      r_den_latch <= 1'b0;
      r_dma_mask  <= '0;
    end else if (bus.i_halfTick) begin
      r_phi <= ~r_phi;
      if (r_phi) begin
        if (w_line_end) begin
          r_cycle  <= 6'd1;
          r_raster <= w_frame_end ? 9'd0 : r_raster + 9'd1;
        end else begin
          r_cycle <= r_cycle + 6'd1;
        end
      end
      if (w_frame_end)
        r_den_latch <= 1'b0;
      else if (r_raster == DISP_FIRST && bus.i_den)
        r_den_latch <= 1'b1;
      if (r_phi && r_cycle == 6'd55)
        r_dma_mask <= bus.i_spriteDma;
    end
  end

  // DEN is honoured live on line 0x30 so a badline can start before the latch sets.
  assign w_window  = (r_raster >= DISP_FIRST) && (r_raster <= DISP_LAST) &&
                     (r_den_latch || (r_raster == DISP_FIRST && bus.i_den));
  assign w_badline = w_window && (r_raster[2:0] == bus.i_yscroll);

  // NOTE: every signal written here gets a default first, so no latches form.
  always_comb begin
    w_spr_ba = 1'b0;
    w_p_hit  = 1'b0;
    w_p_idx  = '0;
    w_s1_hit = 1'b0;
    w_s1_idx = '0;
    for (int n = 0; n < 8; n++) begin
      if (r_dma_mask[n] && in_span(r_cycle, cyc_add(slot_of(n), -3), 5))
        w_spr_ba = 1'b1;
      if (r_cycle == slot_of(n)) begin
        w_p_hit = 1'b1;
        w_p_idx = 3'(n);
      end
      if (r_dma_mask[n] && r_cycle == cyc_add(slot_of(n), 1)) begin
        w_s1_hit = 1'b1;
        w_s1_idx = 3'(n);
      end
    end
  end

  always_comb begin
    w_access = ACC_IDLE;
    w_sprite = '0;
    if (!r_phi) begin
      if (w_p_hit) begin
        w_access = ACC_P;
        w_sprite = w_p_idx;
      end else if (w_s1_hit) begin
        w_access = ACC_S;
        w_sprite = w_s1_idx;
      end else if (r_cycle >= 6'd11 && r_cycle <= 6'd15) begin
        w_access = ACC_REFRESH;
      end else if (r_cycle >= 6'd16 && r_cycle <= 6'd55 && w_window) begin
        w_access = ACC_G;
      end
    end else begin
      w_access = ACC_CPU;
      if (w_p_hit && r_dma_mask[w_p_idx]) begin
        w_access = ACC_S;
        w_sprite = w_p_idx;
      end else if (w_s1_hit) begin
        w_access = ACC_S;
        w_sprite = w_s1_idx;
      end else if (w_badline && r_cycle >= 6'd15 && r_cycle <= 6'd54) begin
        w_access = ACC_C;
      end
    end
  end

  assign bus.o_phi     = r_phi;
  assign bus.o_cycle   = r_cycle;
  assign bus.o_raster  = r_raster;
  assign bus.o_badline = w_badline;
  assign bus.o_access  = w_access;
  assign bus.o_sprite  = w_sprite;
  assign bus.o_aec     = r_phi && (w_access == ACC_CPU);
  assign bus.o_ba      = !((w_badline && r_cycle >= 6'd12 && r_cycle <= 6'd54) ||
                           w_spr_ba);

endmodule

// File: tb/tb_vic_bus_scheduler.sv
// Scoreboard bench for vic_bus_scheduler: a behavioural model queues the
// expected output word per clk; each scenario task pops and compares it.
module tb_vic_bus_scheduler;

  logic clk = 1'b0;
  logic reset;

  vic_bus_scheduler_if bus ();

  vic_bus_scheduler #(
    .CYCLES_PER_LINE(63),
    .LINES_PER_FRAME(312)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          n_pass = 0;
  int          n_total = 0;
  logic [24:0] sb[$];
  logic [24:0] obs;
  logic [24:0] exp_v;

  bit          m_phi;
  int          m_cycle;
  int          m_raster;
  bit          m_den_latch;
  logic [7:0]  m_dma;
  int          p_slot[8] = '{58, 60, 62, 1, 3, 5, 7, 9};

  function automatic int wrapc(input int c);
    return ((c - 1 + 63) % 63) + 1;
  endfunction

  function automatic logic [24:0] model_out();
    bit win, bl, ba_low, aec, done;
    int acc, spr;
    win = m_raster >= 48 && m_raster <= 247 &&
          (m_den_latch || (m_raster == 48 && bus.i_den));
    bl = win && ((m_raster % 8) == int'(bus.i_yscroll));
    ba_low = bl && m_cycle >= 12 && m_cycle <= 54;
    for (int n = 0; n < 8; n++)
      if (m_dma[n])
        for (int k = -3; k <= 1; k++)
          if (wrapc(p_slot[n] + k) == m_cycle) ba_low = 1;
    done = 0;
    acc = 0;
    spr = 0;
    if (!m_phi) begin
      for (int n = 0; n < 8; n++)
        if (!done && m_cycle == p_slot[n]) begin acc = 4; spr = n; done = 1; end
      for (int n = 0; n < 8; n++)
        if (!done && m_dma[n] && m_cycle == wrapc(p_slot[n] + 1)) begin
          acc = 5; spr = n; done = 1;
        end
      if (!done && m_cycle >= 11 && m_cycle <= 15) acc = 1;
      else if (!done && m_cycle >= 16 && m_cycle <= 55 && win) acc = 3;
    end else begin
      acc = 7;
      for (int n = 0; n < 8; n++)
        if (!done && m_dma[n] &&
            (m_cycle == p_slot[n] || m_cycle == wrapc(p_slot[n] + 1))) begin
          acc = 5; spr = n; done = 1;
        end
      if (!done && bl && m_cycle >= 15 && m_cycle <= 54) acc = 2;
    end
    aec = m_phi && acc == 7;
    return {m_phi, 6'(m_cycle), 9'(m_raster), bl, !ba_low, aec, 3'(acc), 3'(spr)};
  endfunction

  task automatic model_edge(input bit rst, input bit tk);
    if (rst) begin
      m_phi = 0; m_cycle = 1; m_raster = 0; m_den_latch = 0; m_dma = '0;
    end else if (tk) begin
      if (m_raster == 48 && bus.i_den) m_den_latch = 1;
      if (m_phi && m_cycle == 55) m_dma = bus.i_spriteDma;
      if (m_phi) begin
        if (m_cycle == 63) begin
          m_cycle = 1;
          if (m_raster == 311) begin m_raster = 0; m_den_latch = 0; end
          else m_raster++;
        end else begin
          m_cycle++;
        end
      end
      m_phi = !m_phi;
    end
  endtask

  // Drives one clk, queues the model prediction, then pops it against the DUT.
  task automatic clock_step(input bit rst, input bit tk);
    reset = rst;
    bus.i_halfTick = tk;
    model_edge(rst, tk);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.i_halfTick = 1'b0;
    obs = {bus.o_phi, bus.o_cycle, bus.o_raster, bus.o_badline, bus.o_ba,
           bus.o_aec, bus.o_access, bus.o_sprite};
    exp_v = sb.pop_front();
  endtask

  task automatic test_reset();
    logic [24:0] rst_vec;
    rst_vec = {1'b0, 6'd1, 9'd0, 1'b0, 1'b1, 1'b0, 3'd4, 3'd3};
    bus.i_den = 0; bus.i_yscroll = 0; bus.i_spriteDma = 0;
    for (int i = 0; i < 2; i++) begin
      clock_step(1, 1);
      n_total++;
      if (obs !== exp_v) $display("FAIL reset_model: observed %h expected %h", obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (obs !== rst_vec) $display("FAIL reset_state: observed %h expected %h", obs, rst_vec);
    else n_pass++;
  endtask

  task automatic test_idle_line();
    int ba_low = 0, aec_bad = 0, ref_cnt = 0, ref_bad = 0;
    for (int i = 0; i < 126; i++) begin
      clock_step(0, 1);
      n_total++;
      if (obs !== exp_v) $display("FAIL idle_model: observed %h expected %h", obs, exp_v);
      else n_pass++;
      if (bus.o_ba !== 1'b1) ba_low++;
      if (bus.o_aec !== bus.o_phi) aec_bad++;
      if (bus.o_access === 3'd1) begin
        ref_cnt++;
        if (bus.o_phi !== 1'b0 || bus.o_cycle < 11 || bus.o_cycle > 15) ref_bad++;
      end
    end
    n_total++;
    if (bus.o_cycle !== 6'd1 || bus.o_raster !== 9'd1 || bus.o_phi !== 1'b0)
      $display("FAIL idle_wrap: observed cycle %0d raster %0d phi %0d expected 1 1 0",
               bus.o_cycle, bus.o_raster, bus.o_phi);
    else n_pass++;
    n_total++;
    if (ba_low !== 0) $display("FAIL idle_ba: observed %0d low samples expected 0", ba_low);
    else n_pass++;
    n_total++;
    if (aec_bad !== 0) $display("FAIL idle_aec: observed %0d bad samples expected 0", aec_bad);
    else n_pass++;
    n_total++;
    if (ref_cnt !== 5 || ref_bad !== 0)
      $display("FAIL idle_refresh: observed %0d (%0d misplaced) expected 5 (0)", ref_cnt, ref_bad);
    else n_pass++;
  endtask

  task automatic test_badline();
    int guard = 0, e_pos = 0, e_bl = 0, e_ba = 0, e_c = 0, e_g = 0;
    bus.i_den = 1; bus.i_yscroll = 3;
    while (!(m_raster == 'h33 && m_cycle == 1 && !m_phi) && guard < 50000) begin
      clock_step(0, 1);
      guard++;
      n_total++;
      if (obs !== exp_v) $display("FAIL badline_run: observed %h expected %h", obs, exp_v);
      else n_pass++;
    end
    for (int c = 1; c <= 63; c++) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (bus.o_cycle !== 6'(c) || bus.o_phi !== 1'(ph)) e_pos++;
        if (bus.o_badline !== 1'b1) e_bl++;
        if (bus.o_ba !== !(c >= 12 && c <= 54)) e_ba++;
        if (ph == 1 && c >= 15 && c <= 54 && (bus.o_aec !== 0 || bus.o_access !== 3'd2)) e_c++;
        if (ph == 1 && (c < 15 || c > 54) && (bus.o_aec !== 1 || bus.o_access !== 3'd7)) e_c++;
        if (ph == 0 && bus.o_aec !== 1'b0) e_c++;
        if (ph == 0 && c >= 16 && c <= 55 && bus.o_access !== 3'd3) e_g++;
        clock_step(0, 1);
        n_total++;
        if (obs !== exp_v) $display("FAIL badline_line: observed %h expected %h", obs, exp_v);
        else n_pass++;
      end
    end
    n_total++;
    if (e_pos + e_bl !== 0) $display("FAIL badline_flag: observed %0d errors expected 0", e_pos + e_bl);
    else n_pass++;
    n_total++;
    if (e_ba !== 0) $display("FAIL badline_ba: observed %0d errors expected 0", e_ba);
    else n_pass++;
    n_total++;
    if (e_c !== 0) $display("FAIL badline_caccess: observed %0d errors expected 0", e_c);
    else n_pass++;
    n_total++;
    if (e_g !== 0) $display("FAIL badline_gaccess: observed %0d errors expected 0", e_g);
    else n_pass++;
  endtask

  task automatic test_yscroll_and_reset();
    int guard = 0;
    bus.i_yscroll = 4;
    clock_step(0, 0);
    n_total++;
    if (obs !== exp_v || bus.o_badline !== 1'b1)
      $display("FAIL yscroll_create: observed %h expected %h", obs, exp_v);
    else n_pass++;
    while (!(m_cycle == 30 && !m_phi) && guard < 200) begin
      if (m_cycle == 20 && !m_phi && bus.i_yscroll == 3'd4) begin
        bus.i_yscroll = 5;
        clock_step(0, 0);
        n_total++;
        if (obs !== exp_v || bus.o_badline !== 1'b0 || bus.o_ba !== 1'b1)
          $display("FAIL yscroll_cancel: observed %h expected %h", obs, exp_v);
        else n_pass++;
        bus.i_yscroll = 4;
      end
      clock_step(0, 1);
      guard++;
      n_total++;
      if (obs !== exp_v) $display("FAIL yscroll_run: observed %h expected %h", obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (bus.o_badline !== 1'b1 || bus.o_ba !== 1'b0 || bus.o_cycle !== 6'd30)
      $display("FAIL midline_pre: observed bl %0d ba %0d cycle %0d expected 1 0 30",
               bus.o_badline, bus.o_ba, bus.o_cycle);
    else n_pass++;
    clock_step(1, 1);
    n_total++;
    if (obs !== exp_v || bus.o_ba !== 1'b1 || bus.o_cycle !== 6'd1 ||
        bus.o_raster !== 9'd0 || bus.o_phi !== 1'b0)
      $display("FAIL midline_reset: observed %h expected %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_den_latch();
    int guard = 0, early_bl = 0;
    bus.i_den = 1; bus.i_yscroll = 0;
    while (!(m_raster == 'h38 && m_cycle == 1 && !m_phi) && guard < 50000) begin
      if (m_raster == 'h31) bus.i_den = 0;
      clock_step(0, 1);
      guard++;
      n_total++;
      if (obs !== exp_v) $display("FAIL denlatch_run: observed %h expected %h", obs, exp_v);
      else n_pass++;
      if (m_raster > 'h30 && m_raster < 'h38 && bus.o_badline === 1'b1) early_bl++;
    end
    n_total++;
    if (early_bl !== 0) $display("FAIL denlatch_quiet: observed %0d expected 0", early_bl);
    else n_pass++;
    n_total++;
    if (bus.o_badline !== 1'b1 || bus.o_raster !== 9'h038)
      $display("FAIL denlatch_badline: observed bl %0d raster %h expected 1 038",
               bus.o_badline, bus.o_raster);
    else n_pass++;
  endtask

  task automatic test_sprite();
    int guard = 0, cyc_list[11] = '{56, 57, 58, 59, 60, 61, 62, 63, 1, 2, 3};
    int e_ba, e_acc, e_spr, errs = 0, c;
    bus.i_spriteDma = 8'h08;
    while (!(m_cycle == 56 && !m_phi) && guard < 200) begin
      clock_step(0, 1);
      guard++;
      n_total++;
      if (obs !== exp_v) $display("FAIL sprite_run: observed %h expected %h", obs, exp_v);
      else n_pass++;
    end
    bus.i_spriteDma = 8'h00;
    for (int i = 0; i < 11; i++) begin
      c = cyc_list[i];
      for (int ph = 0; ph < 2; ph++) begin
        e_ba = (c == 61 || c == 62 || c == 63 || c == 1 || c == 2) ? 0 : 1;
        e_spr = 0;
        if (ph == 0) begin
          case (c)
            58: begin e_acc = 4; e_spr = 0; end
            60: begin e_acc = 4; e_spr = 1; end
            62: begin e_acc = 4; e_spr = 2; end
            1:  begin e_acc = 4; e_spr = 3; end
            2:  begin e_acc = 5; e_spr = 3; end
            3:  begin e_acc = 4; e_spr = 4; end
            default: e_acc = 0;
          endcase
        end else if (c == 1 || c == 2) begin
          e_acc = 5; e_spr = 3;
        end else begin
          e_acc = 7;
        end
        n_total++;
        if (bus.o_cycle !== 6'(c) || bus.o_ba !== 1'(e_ba) ||
            bus.o_access !== 3'(e_acc) || bus.o_sprite !== 3'(e_spr) ||
            bus.o_aec !== 1'(ph == 1 && e_acc == 7)) begin
          errs++;
          $display("FAIL sprite_slot c%0d ph%0d: observed ba %0d acc %0d spr %0d expected %0d %0d %0d",
                   c, ph, bus.o_ba, bus.o_access, bus.o_sprite, e_ba, e_acc, e_spr);
        end else n_pass++;
        clock_step(0, 1);
        n_total++;
        if (obs !== exp_v) $display("FAIL sprite_model: observed %h expected %h", obs, exp_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_frame_wrap();
    int guard = 0;
    while (!(m_raster == 311 && m_cycle == 63 && m_phi) && guard < 50000) begin
      clock_step(0, 1);
      guard++;
      n_total++;
      if (obs !== exp_v) $display("FAIL wrap_run: observed %h expected %h", obs, exp_v);
      else n_pass++;
    end
    n_total++;
    if (bus.o_raster !== 9'd311 || bus.o_cycle !== 6'd63 || bus.o_phi !== 1'b1)
      $display("FAIL wrap_pre: observed raster %0d cycle %0d phi %0d expected 311 63 1",
               bus.o_raster, bus.o_cycle, bus.o_phi);
    else n_pass++;
    clock_step(0, 1);
    n_total++;
    if (obs !== exp_v || bus.o_raster !== 9'd0 || bus.o_cycle !== 6'd1 || bus.o_phi !== 1'b0)
      $display("FAIL wrap_post: observed %h expected %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_den_off_frame();
    int guard = 0, bl_cnt = 0;
    bus.i_den = 0; bus.i_yscroll = 0;
    while (!(m_raster == 'h60 && m_cycle == 1 && !m_phi) && guard < 50000) begin
      clock_step(0, 1);
      guard++;
      n_total++;
      if (obs !== exp_v) $display("FAIL denoff_run: observed %h expected %h", obs, exp_v);
      else n_pass++;
      if (bus.o_badline === 1'b1) bl_cnt++;
    end
    n_total++;
    if (bl_cnt !== 0) $display("FAIL denoff_badlines: observed %0d expected 0", bl_cnt);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    bus.i_halfTick = 0; bus.i_den = 0; bus.i_yscroll = 0; bus.i_spriteDma = 0;
    test_reset();
    test_idle_line();
    test_badline();
    test_yscroll_and_reset();
    test_den_latch();
    test_sprite();
    test_frame_wrap();
    test_den_off_frame();
    n_total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
